inst_fetch_unit: RTL
====================

# inst_fetch_unit

Upstream stage of `inst_reader`: holds the compiled GEMM program in a local instruction memory, sequences it with a program counter and presents one decoded instruction at a time (opcode, buf_id, mem_loc) over a valid/ready handshake. Stops on HALT, on an illegal opcode, or after the last memory word. The program is written through a dedicated write port before `i_start`.

## Interface
- INST_WIDTH, 32, instruction word width
- INST_MEMORY_SIZE, 16, instruction words
- LOG2_INST_MEMORY_SIZE, 4, PC / address width
- OPCODE_WIDTH, 4; BUF_ID_WIDTH, 2; MEM_LOC_WIDTH, 26, field widths (sum = INST_WIDTH)
- opcode_NOP 4'b0000, opcode_LD 4'b0010, opcode_ST 4'b0011, opcode_GEMM 4'b0100, opcode_DRAINSYS 4'b0101, opcode_HALT 4'b1111

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_prog_wr_en  in  1  program write strobe
- i_prog_wr_addr  in  LOG2_INST_MEMORY_SIZE  program write address
- i_prog_wr_data  in  INST_WIDTH  program word
- i_start  in  1  start pulse, PC := 0
- i_inst_ready  in  1  consumer accepts the current instruction
- o_inst_valid  out  1  decoded instruction present
- o_opcode  out  OPCODE_WIDTH  bits [31:28]
- o_buf_id  out  BUF_ID_WIDTH  bits [27:26]
- o_mem_loc  out  MEM_LOC_WIDTH  bits [25:0]
- o_pc  out  LOG2_INST_MEMORY_SIZE  address of the current or next instruction
- o_busy  out  1  high in FETCH/DECODE/ISSUE
- o_done  out  1  sticky; set on program end, cleared by i_start
- o_illegal  out  1  sticky; set with o_done when an unknown opcode stopped the program

## Operation
- States: IDLE, FETCH, DECODE, ISSUE, DONE.
- IDLE/DONE + i_start: PC := 0, clear o_done/o_illegal, go to FETCH. i_start in any other state is ignored.
- FETCH: synchronous memory read at PC. Go to DECODE.
- DECODE: read word available. Decode by opcode:
  - LD/ST/GEMM/DRAINSYS: load output registers, go to ISSUE.
  - NOP: not issued. If PC = SIZE-1, go to DONE; else PC+1 and go to FETCH.
  - HALT: go to DONE. PC stays at the HALT address.
  - Any other opcode: go to DONE and set o_illegal.
- ISSUE: o_inst_valid = 1. All output fields stay stable until i_inst_ready. On the handshake: if PC = SIZE-1, go to DONE (no wrap); else PC+1 and go to FETCH.
- DONE: o_done = 1, o_busy = 0. Waits for i_start.
- Program writes are accepted only in IDLE/DONE. Writes in other states are dropped.
- Memory contents are not reset. Running a program with unwritten words is undefined.

## Timing
- Reset values: o_inst_valid 0, all fields 0, o_pc 0, o_busy 0, o_done 0, o_illegal 0, state IDLE.
- Reset mid-operation: state returns to IDLE immediately and every output goes to its reset value. Memory is retained.
- i_start sampled at edge N: FETCH in cycle N+1, DECODE N+2, o_inst_valid high from N+3.
- Back-to-back with i_inst_ready held high: one instruction every 3 cycles. Each NOP adds 2 cycles.
- o_inst_valid is never asserted in the cycle after a handshake.
- o_done rises in the cycle after the HALT DECODE, or in the cycle after the last-word handshake.
- i_inst_ready while o_inst_valid is low has no effect.
- All outputs are registered. No combinational path from i_inst_ready to any output.

## Structure
- Shared package `gemm_isa_pkg`:
  - opcode constants and field widths/indices (OPCODE_ARRAY_INDEX, BUF_ID_ARRAY_INDEX, MEM_LOC_ARRAY_INDEX)
  - the fetch-state enum
  - the same constants are used by `inst_reader`
- One sub-module: `inst_mem_1r1w`, INST_MEMORY_SIZE x INST_WIDTH, synchronous read, synchronous write, no read-during-write forwarding.

## Test plan
- Program {LD buf0 loc 0x10, LD buf1 loc 0x20, GEMM, DRAINSYS, ST buf2 loc 0x30, HALT}, ready=1 -> five issues in that order with matching fields. o_done rises with o_pc=5, o_illegal=0.
- Same program, ready toggling 1 cycle high / 3 low -> no field change while valid && !ready. No lost or duplicated instructions.
- Word 0 = NOP, word 1 = GEMM, word 2 = opcode 4'b0111 -> GEMM issued first valid at N+5. o_done=1, o_illegal=1, o_pc=2.
- 16 LD words, no HALT -> 16 issues, o_done after the 16th handshake, o_pc=15, no wrap.
- Assert rst_n low during ISSUE of the 3rd instruction, then i_start -> outputs go to reset values. Execution restarts from PC 0 with the program intact.
- i_prog_wr_en during ISSUE and i_start during FETCH -> memory is unchanged and the PC sequence is unaffected.

Source files
------------

// File: rtl/gemm_isa_pkg.sv
// Shared GEMM ISA definitions: field widths, bit positions, opcodes, fetch-state enum.
// Latency: n/a (constants, types and a pure decode helper only).
// Backpressure: n/a.
//
// Used by inst_fetch_unit and inst_reader so both sides agree on the encoding.
// Word layout (INST_WIDTH = 32): [31:28] opcode | [27:26] buf_id | [25:0] mem_loc.
package gemm_isa_pkg;

    localparam int INST_WIDTH            = 32;
    localparam int INST_MEMORY_SIZE      = 16;
    localparam int LOG2_INST_MEMORY_SIZE = 4;

    localparam int OPCODE_WIDTH  = 4;
    localparam int BUF_ID_WIDTH  = 2;
    localparam int MEM_LOC_WIDTH = 26;

    // Low bit position of each field inside an instruction word.
    localparam int OPCODE_ARRAY_INDEX  = MEM_LOC_WIDTH + BUF_ID_WIDTH;
    localparam int BUF_ID_ARRAY_INDEX  = MEM_LOC_WIDTH;
    localparam int MEM_LOC_ARRAY_INDEX = 0;

    localparam logic [OPCODE_WIDTH-1:0] opcode_NOP      = 4'b0000;
    localparam logic [OPCODE_WIDTH-1:0] opcode_LD       = 4'b0010;
    localparam logic [OPCODE_WIDTH-1:0] opcode_ST       = 4'b0011;
    localparam logic [OPCODE_WIDTH-1:0] opcode_GEMM     = 4'b0100;
    localparam logic [OPCODE_WIDTH-1:0] opcode_DRAINSYS = 4'b0101;
    localparam logic [OPCODE_WIDTH-1:0] opcode_HALT     = 4'b1111;

    // Decoded instruction fields, in word order.
    typedef struct packed {
        logic [OPCODE_WIDTH-1:0]  opcode;
        logic [BUF_ID_WIDTH-1:0]  buf_id;
        logic [MEM_LOC_WIDTH-1:0] mem_loc;
    } inst_t;

    typedef enum logic [2:0] {
        FETCH_IDLE   = 3'd0,
        FETCH_FETCH  = 3'd1,
        FETCH_DECODE = 3'd2,
        FETCH_ISSUE  = 3'd3,
        FETCH_DONE   = 3'd4
    } fetch_state_t;

    // Split a raw instruction word into its fields using the shared bit positions.
    function automatic inst_t unpack_inst(input logic [INST_WIDTH-1:0] word);
        inst_t inst;
        inst.opcode  = word[OPCODE_ARRAY_INDEX  +: OPCODE_WIDTH];
        inst.buf_id  = word[BUF_ID_ARRAY_INDEX  +: BUF_ID_WIDTH];
        inst.mem_loc = word[MEM_LOC_ARRAY_INDEX +: MEM_LOC_WIDTH];
        return inst;
    endfunction

endpackage

// File: rtl/inst_mem_1r1w.sv
// Instruction memory, DEPTH x WIDTH, one synchronous write port and one synchronous read port.
// Latency: read data valid the cycle after rd_en; write visible to reads issued after the write edge.
// Backpressure: none; every enabled access completes. No read-during-write forwarding.
//
// Ports:
//   clk                         clock
//   wr_en / wr_addr / wr_data   write port (one word per cycle)
//   rd_en / rd_addr             read request
//   rd_data                     registered read word, held while rd_en is low
// Contents and read register are deliberately not reset so a program survives rst_n.
module inst_mem_1r1w #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Same-address read and write in one cycle returns the old word.
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: sequences the local program memory and presents one decoded instruction at a time.
// Latency: i_start at edge N -> o_inst_valid from N+3; one issue per 3 cycles with ready held, +2 per NOP.
// Backpressure: o_inst_valid/fields held stable in ISSUE until i_inst_ready; no fetch ahead while stalled.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   i_prog_wr_en/_addr/_data         program load port, honoured only in IDLE/DONE
//   i_start                          start pulse, honoured only in IDLE/DONE (PC := 0)
//   i_inst_ready                     consumer accepts the presented instruction
//   o_inst_valid, o_opcode,
//   o_buf_id, o_mem_loc              presented instruction (registered)
//   o_pc                             address of the current or next instruction
//   o_busy                           high in FETCH/DECODE/ISSUE
//   o_done, o_illegal                sticky end-of-program flags, cleared by i_start
module inst_fetch_unit
    import gemm_isa_pkg::*;
(
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             i_prog_wr_en,
    input  logic [LOG2_INST_MEMORY_SIZE-1:0] i_prog_wr_addr,
    input  logic [INST_WIDTH-1:0]            i_prog_wr_data,
    input  logic                             i_start,
    input  logic                             i_inst_ready,
    output logic                             o_inst_valid,
    output logic [OPCODE_WIDTH-1:0]          o_opcode,
    output logic [BUF_ID_WIDTH-1:0]          o_buf_id,
    output logic [MEM_LOC_WIDTH-1:0]         o_mem_loc,
    output logic [LOG2_INST_MEMORY_SIZE-1:0] o_pc,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_illegal
);

    localparam logic [LOG2_INST_MEMORY_SIZE-1:0] PC_LAST =
        LOG2_INST_MEMORY_SIZE'(INST_MEMORY_SIZE - 1);
    localparam logic [LOG2_INST_MEMORY_SIZE-1:0] PC_ONE =
        LOG2_INST_MEMORY_SIZE'(1);

    fetch_state_t          state;
    logic                  prog_wr_ok;
    logic                  mem_rd_en;
    logic [INST_WIDTH-1:0] mem_rd_data;
    inst_t                 dec;
    logic                  state_idle_or_done;

    assign state_idle_or_done = (state == FETCH_IDLE) || (state == FETCH_DONE);

    // Loading a program while it runs would make the fetched sequence ill-defined, so such writes are dropped.
    assign prog_wr_ok = i_prog_wr_en && state_idle_or_done;

    // o_pc is the PC register itself, so the read address is always the PC.
    assign mem_rd_en  = (state == FETCH_FETCH);

    assign dec = unpack_inst(mem_rd_data);

    inst_mem_1r1w #(
        .DEPTH (INST_MEMORY_SIZE),
        .WIDTH (INST_WIDTH),
        .AW    (LOG2_INST_MEMORY_SIZE)
    ) u_inst_mem (
        .clk     (clk),
        .wr_en   (prog_wr_ok),
        .wr_addr (i_prog_wr_addr),
        .wr_data (i_prog_wr_data),
        .rd_en   (mem_rd_en),
        .rd_addr (o_pc),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH_IDLE;
            o_inst_valid <= 1'b0;
            o_opcode     <= '0;
            o_buf_id     <= '0;
            o_mem_loc    <= '0;
            o_pc         <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_illegal    <= 1'b0;
        end else begin
            case (state)
                FETCH_IDLE, FETCH_DONE: begin
                    if (i_start) begin
                        o_pc      <= '0;
                        o_done    <= 1'b0;
                        o_illegal <= 1'b0;
                        o_busy    <= 1'b1;
                        state     <= FETCH_FETCH;
                    end
                end

                // Read of mem[o_pc] is launched this cycle; word lands in mem_rd_data for DECODE.
                FETCH_FETCH: begin
                    state <= FETCH_DECODE;
                end

                FETCH_DECODE: begin
                    case (dec.opcode)
                        opcode_LD, opcode_ST, opcode_GEMM, opcode_DRAINSYS: begin
                            o_opcode     <= dec.opcode;
                            o_buf_id     <= dec.buf_id;
                            o_mem_loc    <= dec.mem_loc;
                            o_inst_valid <= 1'b1;
                            state        <= FETCH_ISSUE;
                        end
                        // NOPs are consumed here and never reach the consumer.
                        opcode_NOP: begin
                            if (o_pc == PC_LAST) begin
                                o_busy <= 1'b0;
                                o_done <= 1'b1;
                                state  <= FETCH_DONE;
                            end else begin
                                o_pc  <= o_pc + PC_ONE;
                                state <= FETCH_FETCH;
                            end
                        end
                        // PC is left pointing at the HALT word.
                        opcode_HALT: begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= FETCH_DONE;
                        end
                        default: begin
                            o_busy    <= 1'b0;
                            o_done    <= 1'b1;
                            o_illegal <= 1'b1;
                            state     <= FETCH_DONE;
                        end
                    endcase
                end

                // Fields are only reloaded in DECODE, so they hold until the handshake.
                FETCH_ISSUE: begin
                    if (i_inst_ready) begin
                        o_inst_valid <= 1'b0;
                        // The last word ends the program; the PC does not wrap.
                        if (o_pc == PC_LAST) begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= FETCH_DONE;
                        end else begin
                            o_pc  <= o_pc + PC_ONE;
                            state <= FETCH_FETCH;
                        end
                    end
                end

                default: begin
                    o_inst_valid <= 1'b0;
                    o_busy       <= 1'b0;
                    state        <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule
